player_ctl: RTL and testbench
=============================

# player_ctl

Per-frame movement controller for the player sprite. Samples the left/right/jump buttons once per video frame, at the rising edge of vertical blanking. Produces `xpos_player`, `ypos_player` and `state` (type `State` from `state_pkg`) for the player-drawing stage downstream in the VGA pipeline. Contains a horizontal position integrator with clamping and a jump state machine with rise, apex-hold and fall phases.

## Interface
- `X_START`, 300: x position after reset.
- `X_MIN`, 0: leftmost allowed x.
- `X_MAX`, 760: rightmost allowed x (screen width 800 minus sprite width 40).
- `X_STEP`, 4: horizontal pixels moved per frame.
- `Y_GROUND`, 100: `ypos_player` value when on the ground. Must be ≥ `JUMP_H`.
- `JUMP_H`, 80: maximum jump height in pixels.
- `JUMP_STEP`, 8: vertical pixels per frame while rising or falling.
- `APEX_FRAMES`, 4: number of frame ticks spent in APEX.
- `clk`  in  1  system/pixel clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `vblnk`  in  1  vertical blank from the VGA timing chain; same clock domain as `clk`.
- `en`  in  1  when low, frame ticks are ignored and all state holds.
- `btn_left`  in  1  asynchronous button input.
- `btn_right`  in  1  asynchronous button input.
- `btn_jump`  in  1  asynchronous button input.
- `xpos_player`  out  12  sprite x offset, registered.
- `ypos_player`  out  12  sprite y offset, registered; equals `Y_GROUND` minus jump height.
- `state`  out  State  IDLE / RIGHT / LEFT, registered.
- `airborne`  out  1  high whenever the jump FSM is not in GROUND.

## Operation
- **Button synchronisation:** each button passes through its own 2-FF synchroniser. Only the synchronised values are used below.
- **Frame tick:** `vblnk_prev` registers `vblnk` every cycle. `tick = vblnk & ~vblnk_prev & en`. All position, state and FSM updates happen only on cycles where `tick` is high.
- **Horizontal update, on tick:**
  - left=1, right=0: `state`=LEFT, `x = max(x - X_STEP, X_MIN)`. The subtraction must not underflow: compare `x < X_MIN + X_STEP` before subtracting.
  - right=1, left=0: `state`=RIGHT, `x = min(x + X_STEP, X_MAX)`.
  - both or neither pressed: `state`=IDLE, x holds.
  - When x is clamped at a limit, `state` still reports the pressed direction.
- **Jump FSM:** states GROUND, RISE, APEX, FALL. Internal height `h` is 12 bits; `apex_cnt` is wide enough to hold `APEX_FRAMES`.
  - `jump_prev` stores the synchronised jump level at every tick. A jump edge is jump=1 with `jump_prev`=0. Holding the button never retriggers; it must be seen released at one tick first.
  - GROUND: a jump edge moves to RISE and sets `h = JUMP_STEP` on that same tick.
  - RISE: `h = min(h + JUMP_STEP, JUMP_H)`. When the result equals `JUMP_H`, move to APEX and clear `apex_cnt`.
  - APEX: h holds and `apex_cnt` increments. On the tick where `apex_cnt` reaches `APEX_FRAMES - 1`, move to FALL.
  - FALL: `h = max(h - JUMP_STEP, 0)`. When the result is 0, move to GROUND.
  - Jump edges outside GROUND are ignored, but `jump_prev` still updates.
  - Horizontal movement is independent of the jump FSM and stays active while airborne.
- `ypos_player = Y_GROUND - h`. This is registered, never below `Y_GROUND - JUMP_H`, and never above `Y_GROUND`.

## Timing
- **Reset values:** `xpos_player`=`X_START`, `ypos_player`=`Y_GROUND`, `state`=IDLE, `airborne`=0. Internally: FSM=GROUND, h=0, `apex_cnt`=0, `jump_prev`=0, `vblnk_prev`=0, synchronisers=0.
- Asserting `rst_n` low mid-jump or mid-move returns all outputs to their reset values immediately, with no clock required.
- **Output latency:** outputs change on the clock edge where `vblnk`=1 and `vblnk_prev`=0, which is 1 cycle after `vblnk` rises. They then hold for the rest of the frame.
- **Button latency:** a press must be stable for at least 2 clk cycles before the tick edge to be seen at that tick.
- **`en` low:** no updates occur, and edge state (`jump_prev`) is frozen. `vblnk_prev` keeps tracking, so re-enabling mid-vblank does not create a spurious tick.
- **Default jump profile:** starts on tick 1. RISE runs ticks 1–10 (h=8…80; APEX entered at tick 10). APEX runs ticks 11–14 (FALL entered at tick 14). FALL runs ticks 15–24 (h=72…0). GROUND is entered at tick 24, and `airborne`=0 from tick 24.

## Test plan
- **Reset:** hold `rst_n`=0 with random buttons, then release and generate 3 ticks with no buttons → x=300, y=100, `state`=IDLE, no change across the ticks.
- **Right move and clamp:** right held for 120 ticks → x increments by 4 per tick to 760, stays at 760, and `state`=RIGHT throughout. Then left+right held → `state`=IDLE, x=760.
- **Left move and clamp:** from x=6, left held → x=2 then 0 then 0 (no wrap to 4094), `state`=LEFT.
- **Jump profile:** single jump press held for 30 ticks → y sequence 92, 84, …, 20; then 20 held for 4 ticks; then 28…100; `airborne` high for exactly ticks 1–23. No retrigger while the button stays held.
- **Tick qualification:** `vblnk` held high for 50 cycles → exactly one update. With `en`=0 across 5 vblank edges → outputs frozen.
- **Async reset mid-jump:** pulse `rst_n` low at tick 12 (APEX) without a clock edge → y=100, `airborne`=0, x=300 immediately.

Source files
------------

// File: rtl/player_ctl_if.sv
// Player controller types and the frame/button/sprite bundle between the VGA
// timing chain and the player-drawing stage.
package state_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RIGHT = 2'd1,
    LEFT  = 2'd2
  } State;
endpackage

interface player_ctl_if;
  import state_pkg::*;

  logic        vblnk;
  logic        en;
  logic        btn_left;
  logic        btn_right;
  logic        btn_jump;
  logic [11:0] xpos_player;
  logic [11:0] ypos_player;
  State        state;
  logic        airborne;

  modport master (
    output vblnk, en, btn_left, btn_right, btn_jump,
    input  xpos_player, ypos_player, state, airborne
  );

  modport slave (
    input  vblnk, en, btn_left, btn_right, btn_jump,
    output xpos_player, ypos_player, state, airborne
  );
endinterface

// File: rtl/player_ctl.sv
// Per-frame player movement: clamped horizontal integrator plus a
// rise/apex/fall jump machine, both advanced once per vblank rising edge.
module player_ctl
  import state_pkg::*;
#(
  parameter int X_START     = 300,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 760,
  parameter int X_STEP      = 4,
  parameter int Y_GROUND    = 100,
  parameter int JUMP_H      = 80,
  parameter int JUMP_STEP   = 8,
  parameter int APEX_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  player_ctl_if.slave pif
);

  localparam int APEX_W = $clog2(APEX_FRAMES + 1);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    APEX   = 2'd2,
    FALL   = 2'd3
  } jump_state_t;

  // bit 0 = left, bit 1 = right, bit 2 = jump
  logic [2:0] btn_raw;
  logic [2:0] btn_sync;

  assign btn_raw = {pif.btn_jump, pif.btn_right, pif.btn_left};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= btn_raw[gi];
          sync_reg <= meta_reg;
        end
      end
      assign btn_sync[gi] = sync_reg;
    end
  endgenerate

  logic              vblnk_prev_reg;
  logic              tick;
  logic [11:0]       x_reg, x_next;
  logic [11:0]       y_reg, y_next;
  logic [11:0]       h_reg, h_next;
  logic [APEX_W-1:0] apex_reg, apex_next;
  logic              jump_prev_reg, jump_prev_next;
  State              state_reg, state_next;
  jump_state_t       fsm_reg, fsm_next;
  logic [12:0]       x_sum;
  logic [12:0]       h_sum;

  // vblnk_prev tracks even while disabled so re-enabling mid-vblank is silent
  assign tick = pif.vblnk & ~vblnk_prev_reg & pif.en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev_reg <= 1'b0;
      x_reg          <= 12'(X_START);
      y_reg          <= 12'(Y_GROUND);
      h_reg          <= '0;
      apex_reg       <= '0;
      jump_prev_reg  <= 1'b0;
      state_reg      <= IDLE;
      fsm_reg        <= GROUND;
    end else begin
      vblnk_prev_reg <= pif.vblnk;
      x_reg          <= x_next;
      y_reg          <= y_next;
      h_reg          <= h_next;
      apex_reg       <= apex_next;
      jump_prev_reg  <= jump_prev_next;
      state_reg      <= state_next;
      fsm_reg        <= fsm_next;
    end
  end

  always_comb begin
    x_next         = x_reg;
    y_next         = y_reg;
    h_next         = h_reg;
    apex_next      = apex_reg;
    jump_prev_next = jump_prev_reg;
    state_next     = state_reg;
    fsm_next       = fsm_reg;
    x_sum          = '0;
    h_sum          = '0;

    if (tick) begin
      jump_prev_next = btn_sync[2];

      // Direction is reported even when the position is pinned at a limit
      if (btn_sync[0] && !btn_sync[1]) begin
        state_next = LEFT;
        x_next     = (x_reg < 12'(X_MIN + X_STEP)) ? 12'(X_MIN)
                                                   : x_reg - 12'(X_STEP);
      end else if (btn_sync[1] && !btn_sync[0]) begin
        state_next = RIGHT;
        x_sum      = {1'b0, x_reg} + 13'(X_STEP);
        x_next     = (x_sum > 13'(X_MAX)) ? 12'(X_MAX) : x_sum[11:0];
      end else begin
        state_next = IDLE;
      end

      case (fsm_reg)
        GROUND: begin
          if (btn_sync[2] && !jump_prev_reg) begin
            fsm_next = RISE;
            h_next   = 12'(JUMP_STEP);
          end
        end
        RISE: begin
          h_sum = {1'b0, h_reg} + 13'(JUMP_STEP);
          if (h_sum >= 13'(JUMP_H)) begin
            h_next    = 12'(JUMP_H);
            fsm_next  = APEX;
            apex_next = '0;
          end else begin
            h_next = h_sum[11:0];
          end
        end
        APEX: begin
          apex_next = apex_reg + APEX_W'(1);
          if (apex_reg == APEX_W'(APEX_FRAMES - 1)) begin
            fsm_next = FALL;
          end
        end
        FALL: begin
          if (h_reg <= 12'(JUMP_STEP)) begin
            h_next   = '0;
            fsm_next = GROUND;
          end else begin
            h_next = h_reg - 12'(JUMP_STEP);
          end
        end
        default: fsm_next = GROUND;
      endcase

      y_next = 12'(Y_GROUND) - h_next;
    end
  end

  assign pif.xpos_player = x_reg;
  assign pif.ypos_player = y_reg;
  assign pif.state       = state_reg;
  assign pif.airborne    = (fsm_reg != GROUND);

endmodule

// File: tb/tb_player_ctl.sv
// Scoreboard bench for player_ctl: a behavioural model pushes the expected
// outputs per frame tick, which are popped and compared after the tick edge.
module tb_player_ctl;
  import state_pkg::*;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] x6;
    logic [11:0] y;
    logic [1:0]  st;
    logic        air;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic vblnk = 1'b0;
  logic en    = 1'b1;
  logic bl    = 1'b0;
  logic br    = 1'b0;
  logic bj    = 1'b0;

  always #5 clk = ~clk;

  player_ctl_if ifc ();
  player_ctl_if ifc6 ();

  assign ifc.vblnk      = vblnk;
  assign ifc.en         = en;
  assign ifc.btn_left   = bl;
  assign ifc.btn_right  = br;
  assign ifc.btn_jump   = bj;
  assign ifc6.vblnk     = vblnk;
  assign ifc6.en        = en;
  assign ifc6.btn_left  = bl;
  assign ifc6.btn_right = br;
  assign ifc6.btn_jump  = bj;

  player_ctl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (ifc.slave)
  );

  // Second instance starts at x=6 to reach the left limit off the step grid
  player_ctl #(.X_START(6)) u_dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (ifc6.slave)
  );

  int   checks   = 0;
  int   failures = 0;
  obs_t sb[$];
  obs_t exp_cur;
  obs_t got;
  obs_t want;

  logic [11:0] mx, mx6;
  int          k;
  logic        mjp;

  function automatic obs_t observe();
    return {ifc.xpos_player, ifc6.xpos_player, ifc.ypos_player,
            2'(ifc.state), ifc.airborne};
  endfunction

  function automatic logic [11:0] step_x(logic [11:0] x, logic l, logic r);
    int t = int'(x);
    if (l && !r) t = t - 4;
    else if (r && !l) t = t + 4;
    if (t < 0) t = 0;
    if (t > 760) t = 760;
    return 12'(t);
  endfunction

  // Default jump profile indexed by ticks since the press (0 = on ground)
  function automatic logic [11:0] y_of(int kk);
    if (kk == 0) return 12'd100;
    if (kk <= 10) return 12'(100 - 8 * kk);
    if (kk <= 14) return 12'd20;
    return 12'(20 + 8 * (kk - 14));
  endfunction

  task automatic model_reset();
    mx      = 12'd300;
    mx6     = 12'd6;
    k       = 0;
    mjp     = 1'b0;
    exp_cur = {12'd300, 12'd6, 12'd100, 2'(IDLE), 1'b0};
  endtask

  task automatic model_step(input logic l, input logic r, input logic j);
    State s;
    mx  = step_x(mx, l, r);
    mx6 = step_x(mx6, l, r);
    s   = (l && !r) ? LEFT : ((r && !l) ? RIGHT : IDLE);
    if (k == 0) begin
      if (j && !mjp) k = 1;
    end else begin
      k = k + 1;
    end
    mjp     = j;
    exp_cur = {mx, mx6, y_of(k), 2'(s), (k >= 1 && k <= 23)};
    if (k == 24) k = 0;
  endtask

  task automatic frame(input logic l, input logic r, input logic j, output obs_t o);
    @(negedge clk);
    bl = l; br = r; bj = j;
    repeat (3) @(negedge clk);
    model_step(l, r, j);
    sb.push_back(exp_cur);
    vblnk = 1'b1;
    @(posedge clk);
    #1;
    o = observe();
    repeat (3) @(negedge clk);
    vblnk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    bl = 1'b0; br = 1'b0; bj = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      bl = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1));
      bj = 1'($urandom_range(0, 1));
    end
    model_reset();
    sb.push_back(exp_cur);
    got = observe(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_hold got=%h want=%h (x,x6,y,st,air)", got, want);
    end else $display("ok reset_hold x=%0d y=%0d st=%0d", got.x, got.y, got.st);
    @(negedge clk);
    bl = 1'b0; br = 1'b0; bj = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frame(1'b0, 1'b0, 1'b0, got);
      want = sb.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL reset_idle[%0d] got=%h want=%h", i, got, want);
      end else $display("ok reset_idle[%0d] x=%0d y=%0d", i, got.x, got.y);
    end
  endtask

  task automatic test_right_clamp();
    for (int i = 0; i < 122; i++) begin
      if (i < 120) frame(1'b0, 1'b1, 1'b0, got);
      else         frame(1'b1, 1'b1, 1'b0, got);
      want = sb.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL right[%0d] got=%h want=%h", i, got, want);
      end else $display("ok right[%0d] x=%0d x6=%0d st=%0d", i, got.x, got.x6, got.st);
    end
  endtask

  task automatic test_left_clamp();
    reset_pulse();
    for (int i = 0; i < 3; i++) begin
      frame(1'b1, 1'b0, 1'b0, got);
      want = sb.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL left[%0d] got=%h want=%h", i, got, want);
      end else $display("ok left[%0d] x=%0d x6=%0d st=%0d", i, got.x, got.x6, got.st);
    end
  endtask

  task automatic test_jump();
    for (int i = 0; i < 31; i++) begin
      frame(1'b0, 1'b0, (i < 30), got);
      want = sb.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL jump[%0d] got=%h want=%h", i + 1, got, want);
      end else $display("ok jump[%0d] y=%0d air=%0d", i + 1, got.y, got.air);
    end
  endtask

  task automatic test_tick_qual();
    @(negedge clk);
    bl = 1'b0; br = 1'b1; bj = 1'b0;
    repeat (3) @(negedge clk);
    model_step(1'b0, 1'b1, 1'b0);
    sb.push_back(exp_cur);
    sb.push_back(exp_cur);
    vblnk = 1'b1;
    @(posedge clk);
    #1;
    got = observe(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL vhold_first got=%h want=%h", got, want);
    end else $display("ok vhold_first x=%0d", got.x);
    repeat (49) @(posedge clk);
    #1;
    got = observe(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL vhold_last got=%h want=%h", got, want);
    end else $display("ok vhold_last x=%0d", got.x);
    @(negedge clk);
    vblnk = 1'b0;
    repeat (3) @(negedge clk);

    // Jump pressed while disabled must still count as an edge once enabled
    en = 1'b0;
    bj = 1'b1;
    repeat (5) begin
      @(negedge clk); vblnk = 1'b1;
      repeat (3) @(negedge clk);
      vblnk = 1'b0;
      repeat (3) @(negedge clk);
    end
    sb.push_back(exp_cur);
    got = observe(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL en_low got=%h want=%h", got, want);
    end else $display("ok en_low x=%0d y=%0d", got.x, got.y);

    @(negedge clk);
    vblnk = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);
    sb.push_back(exp_cur);
    got = observe(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL en_midvblank got=%h want=%h", got, want);
    end else $display("ok en_midvblank x=%0d y=%0d", got.x, got.y);
    vblnk = 1'b0;
    repeat (2) @(negedge clk);

    frame(1'b0, 1'b0, 1'b1, got);
    want = sb.pop_front(); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL jump_after_en got=%h want=%h", got, want);
    end else $display("ok jump_after_en y=%0d air=%0d", got.y, got.air);
  endtask

  task automatic test_async_reset();
    reset_pulse();
    for (int i = 0; i < 12; i++) begin
      frame((i < 4), 1'b0, 1'b1, got);
      want = sb.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL pre_reset[%0d] got=%h want=%h", i + 1, got, want);
      end else $display("ok pre_reset[%0d] x=%0d y=%0d air=%0d", i + 1, got.x, got.y, got.air);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    sb.push_back(exp_cur);
    got = observe(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL async_reset got=%h want=%h", got, want);
    end else $display("ok async_reset x=%0d y=%0d air=%0d", got.x, got.y, got.air);
    @(negedge clk);
    bl = 1'b0; br = 1'b0; bj = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_right_clamp();
    test_left_clamp();
    test_jump();
    test_tick_qual();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
